// File: rtl/universal_register.sv
// Purpose : WIDTH-bit universal register: hold, load, shift, rotate, inc, dec.
// Latency : one CLK edge from inputs to Q/CO/ZERO; every output is registered.
// Backpressure: none; each edge with EN=1 performs exactly one operation.
//
// Ports:
//   CLK   - clock, all state updates on rising edge
//   RST_N - synchronous active-low reset (Q=RESET_VALUE, CO=0)
//   EN    - operation enable; when low, all outputs hold
//   MODE  - 000 hold, 001 load, 010 shl, 011 shr, 100 rol, 101 ror, 110 inc, 111 dec
//   D     - parallel load data
//   SIN   - serial input for shift modes (ignored by rotates)
//   Q     - registered value
//   CO    - registered carry / borrow / shift-out
//   ZERO  - registered (Q == 0)
module universal_register #(
  parameter int unsigned           WIDTH       = 8,
  parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             EN,
  input  logic [2:0]       MODE,
  input  logic [WIDTH-1:0] D,
  input  logic             SIN,
  output logic [WIDTH-1:0] Q,
  output logic             CO,
  output logic             ZERO
);

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_SHR  = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_ROR  = 3'b101;
  localparam logic [2:0] MODE_INC  = 3'b110;
  localparam logic [2:0] MODE_DEC  = 3'b111;

  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  logic [WIDTH-1:0] q_next;
  logic             co_next;

  // Next-state for an enabled operation; reset and EN gating live in the flop.
  always_comb begin
    q_next  = Q;
    co_next = CO;
    case (MODE)
      MODE_HOLD: begin
        q_next  = Q;
        co_next = CO;
      end
      MODE_LOAD: begin
        q_next  = D;
        co_next = 1'b0;
      end
      MODE_SHL: begin
        q_next  = {Q[WIDTH-2:0], SIN};
        co_next = Q[WIDTH-1];
      end
      MODE_SHR: begin
        q_next  = {SIN, Q[WIDTH-1:1]};
        co_next = Q[0];
      end
      MODE_ROL: begin
        q_next  = {Q[WIDTH-2:0], Q[WIDTH-1]};
        co_next = Q[WIDTH-1];
      end
      MODE_ROR: begin
        q_next  = {Q[0], Q[WIDTH-1:1]};
        co_next = Q[0];
      end
      MODE_INC: begin
        q_next  = Q + ONE;
        co_next = (Q == ALL_ONES);
      end
      MODE_DEC: begin
        q_next  = Q - ONE;
        co_next = (Q == '0);
      end
      default: begin
        q_next  = Q;
        co_next = CO;
      end
    endcase
  end

  // ZERO is computed from the value being written so it tracks Q with no lag.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      Q    <= RESET_VALUE;
      CO   <= 1'b0;
      ZERO <= (RESET_VALUE == '0);
    end else if (EN) begin
      Q    <= q_next;
      CO   <= co_next;
      ZERO <= (q_next == '0);
    end
  end

endmodule

// File: tb/tb_universal_register.sv
module tb_universal_register;

  typedef struct packed {
    logic [7:0] q;
    logic       co;
    logic       z;
  } exp_t;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       EN = 1'b0;
  logic [2:0] MODE = 3'b000;
  logic [7:0] D = 8'h00;
  logic       SIN = 1'b0;
  logic [7:0] Q;
  logic       CO;
  logic       ZERO;

  int checks = 0;
  int errors = 0;

  exp_t exp_q[$];

  // Bench reference state
  logic [7:0] m_q;
  logic       m_co;

  universal_register #(.WIDTH(8), .RESET_VALUE(8'h00)) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .EN   (EN),
    .MODE (MODE),
    .D    (D),
    .SIN  (SIN),
    .Q    (Q),
    .CO   (CO),
    .ZERO (ZERO)
  );

  always #5 CLK = ~CLK;

  // Advance the reference model by one edge with the given inputs.
  task automatic model_edge(input logic rn, input logic en, input logic [2:0] mode,
                            input logic [7:0] d, input logic sin);
    logic [8:0] wide;
    if (!rn) begin
      m_q  = 8'h00;
      m_co = 1'b0;
    end else if (en) begin
      case (mode)
        3'd0: ;
        3'd1: begin m_q = d; m_co = 1'b0; end
        3'd2: begin m_co = m_q[7]; m_q = (m_q << 1) | {7'd0, sin}; end
        3'd3: begin m_co = m_q[0]; m_q = (m_q >> 1) | {sin, 7'd0}; end
        3'd4: begin m_co = m_q[7]; m_q = (m_q << 1) | (m_q >> 7); end
        3'd5: begin m_co = m_q[0]; m_q = (m_q >> 1) | (m_q << 7); end
        3'd6: begin wide = {1'b0, m_q} + 9'd1; m_co = wide[8]; m_q = wide[7:0]; end
        default: begin wide = {1'b0, m_q} - 9'd1; m_co = wide[8]; m_q = wide[7:0]; end
      endcase
    end
  endtask

  // Drive one edge's worth of stimulus, push the expectation, then check it.
  task automatic step(input string tag, input logic rn, input logic en,
                      input logic [2:0] mode, input logic [7:0] d, input logic sin);
    exp_t e;
    @(negedge CLK);
    RST_N = rn;
    EN    = en;
    MODE  = mode;
    D     = d;
    SIN   = sin;
    model_edge(rn, en, mode, d, sin);
    exp_q.push_back('{q: m_q, co: m_co, z: (m_q == 8'h00)});
    @(posedge CLK);
    #1;
    e = exp_q.pop_front();
    checks++;
    assert (Q === e.q) else begin
      errors++;
      $error("FAIL %s q: got %h expected %h", tag, Q, e.q);
    end
    checks++;
    assert (CO === e.co) else begin
      errors++;
      $error("FAIL %s co: got %b expected %b", tag, CO, e.co);
    end
    checks++;
    assert (ZERO === e.z) else begin
      errors++;
      $error("FAIL %s zero: got %b expected %b", tag, ZERO, e.z);
    end
  endtask

  // Direct check of the outputs against hand-derived constants.
  task automatic chk(input string tag, input logic [7:0] q, input logic co, input logic z);
    checks++;
    assert (Q === q && CO === co && ZERO === z) else begin
      errors++;
      $error("FAIL %s: got q=%h co=%b zero=%b expected q=%h co=%b zero=%b",
             tag, Q, CO, ZERO, q, co, z);
    end
  endtask

  initial begin
    m_q  = 8'h00;
    m_co = 1'b0;

    // Reset overrides an enabled load of 0xFF
    step("reset", 1'b0, 1'b1, 3'b001, 8'hFF, 1'b0);
    chk("reset_const", 8'h00, 1'b0, 1'b1);

    // Load then shift left with SIN=1
    step("load_a5", 1'b1, 1'b1, 3'b001, 8'hA5, 1'b0);
    chk("load_a5_const", 8'hA5, 1'b0, 1'b0);
    step("shl", 1'b1, 1'b1, 3'b010, 8'h00, 1'b1);
    chk("shl_const", 8'h4B, 1'b1, 1'b0);

    // Hold retains Q and CO
    step("hold", 1'b1, 1'b1, 3'b000, 8'hFF, 1'b1);
    chk("hold_const", 8'h4B, 1'b1, 1'b0);

    // Shift right with SIN=1, rotate left ignoring SIN
    step("shr", 1'b1, 1'b1, 3'b011, 8'h00, 1'b1);
    chk("shr_const", 8'hA5, 1'b1, 1'b0);
    step("rol", 1'b1, 1'b1, 3'b100, 8'h00, 1'b0);
    chk("rol_const", 8'h4B, 1'b1, 1'b0);

    // Increment wrap
    step("load_ff", 1'b1, 1'b1, 3'b001, 8'hFF, 1'b0);
    step("inc_wrap", 1'b1, 1'b1, 3'b110, 8'h00, 1'b0);
    chk("inc_wrap_const", 8'h00, 1'b1, 1'b1);
    step("inc_again", 1'b1, 1'b1, 3'b110, 8'h00, 1'b0);
    chk("inc_again_const", 8'h01, 1'b0, 1'b0);

    // Decrement wrap and rotate right
    step("load_00", 1'b1, 1'b1, 3'b001, 8'h00, 1'b0);
    step("dec_wrap", 1'b1, 1'b1, 3'b111, 8'h00, 1'b0);
    chk("dec_wrap_const", 8'hFF, 1'b1, 1'b0);
    step("load_01", 1'b1, 1'b1, 3'b001, 8'h01, 1'b0);
    step("ror", 1'b1, 1'b1, 3'b101, 8'h00, 1'b0);
    chk("ror_const", 8'h80, 1'b1, 1'b0);

    // Enable low, then reset mid-increment
    step("load_10", 1'b1, 1'b1, 3'b001, 8'h10, 1'b0);
    step("en_low", 1'b1, 1'b0, 3'b001, 8'h33, 1'b1);
    chk("en_low_const", 8'h10, 1'b0, 1'b0);
    step("mid_reset", 1'b0, 1'b1, 3'b110, 8'h00, 1'b0);
    chk("mid_reset_const", 8'h00, 1'b0, 1'b1);
    step("post_reset_inc", 1'b1, 1'b1, 3'b110, 8'h00, 1'b0);
    chk("post_reset_inc_const", 8'h01, 1'b0, 1'b0);

    // Back-to-back random operations against the reference model
    for (int i = 0; i < 300; i++) begin
      step("rand",
           ($urandom_range(0, 19) != 0),
           ($urandom_range(0, 3) != 0),
           3'($urandom_range(0, 7)),
           8'($urandom_range(0, 255)),
           1'($urandom_range(0, 1)));
    end

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain: got %0d expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
